// File: rtl/tmds_decoder_pkg.sv
// Shared TMDS definitions: FSM state type, the four control tokens and
// their 2-bit control values, and the slip-offset advance helper.
package tmds_decoder_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Control tokens as they appear on the wire (bit 0 earliest).
  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  // Control values {c1,c0} carried by the tokens above.
  localparam logic [1:0] CTRL_00 = 2'b00;
  localparam logic [1:0] CTRL_01 = 2'b01;
  localparam logic [1:0] CTRL_10 = 2'b10;
  localparam logic [1:0] CTRL_11 = 2'b11;

  localparam logic [3:0] SLIP_MAX = 4'd9;

  // Next bit-slip offset; offsets run 0..9 and wrap.
  function automatic logic [3:0] next_offset(input logic [3:0] offset);
    logic [3:0] nxt;
    if (offset >= SLIP_MAX) begin
      nxt = 4'd0;
    end else begin
      nxt = offset + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tmds_decoder_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into either a
// control value (is_ctrl=1) or 8-bit pixel data (is_ctrl=0).
module tmds_symbol_decode
  import tmds_decoder_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d_s;

  // Token match; anything that is not one of the four tokens is data.
  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = CTRL_00;
    case (sym)
      TOKEN_C00: ctrl = CTRL_00;
      TOKEN_C01: ctrl = CTRL_01;
      TOKEN_C10: ctrl = CTRL_10;
      TOKEN_C11: ctrl = CTRL_11;
      default: begin
        is_ctrl = 1'b0;
        ctrl    = CTRL_00;
      end
    endcase
  end

  // Undo the encoder's optional inversion (bit 9) and XOR/XNOR chain (bit 8).
  always_comb begin
    d_s     = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = d_s[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d_s[i] ^ d_s[i-1]) : ~(d_s[i] ^ d_s[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// One-channel TMDS receive decoder: bit-slip word alignment locked on
// control tokens, followed by symbol decode to data/control with DE.
module tmds_decoder
  import tmds_decoder_pkg::*;
#(
  parameter int SLIP_WAIT  = 2048,
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT    = 4096,
  parameter int CNTW       = 13
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] sym_in,
  output logic       locked,
  output logic [3:0] slip_offset,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl
);

  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(SLIP_WAIT - 1);
  localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(LOCK_COUNT - 1);
  localparam logic [CNTW-1:0] IDLE_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_SAT   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  logic [9:0]      sym_in_r;
  logic [9:0]      sym_prev_r;
  logic [19:0]     cat_s;
  logic [9:0]      aligned_s;
  state_t          state_r;
  logic [CNTW-1:0] wait_r;
  logic [CNTW-1:0] run_r;
  logic [CNTW-1:0] idle_r;
  logic [3:0]      slip_r;
  logic            lock_nxt_s;
  logic            is_ctrl_s;
  logic [1:0]      dec_ctrl_s;
  logic [7:0]      dec_data_s;
  logic            locked_r;
  logic            de_r;
  logic [7:0]      data_r;
  logic [1:0]      ctrl_r;

  // Input pipeline: current and previous deserializer words.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      sym_in_r   <= 10'h000;
      sym_prev_r <= 10'h000;
    end else begin
      sym_in_r   <= sym_in;
      sym_prev_r <= sym_in_r;
    end
  end

  assign cat_s = {sym_in_r, sym_prev_r};

  // Bit-slip barrel: pick the 10-bit window starting at slip_r.
  always_comb begin
    case (slip_r)
      4'd0:    aligned_s = cat_s[9:0];
      4'd1:    aligned_s = cat_s[10:1];
      4'd2:    aligned_s = cat_s[11:2];
      4'd3:    aligned_s = cat_s[12:3];
      4'd4:    aligned_s = cat_s[13:4];
      4'd5:    aligned_s = cat_s[14:5];
      4'd6:    aligned_s = cat_s[15:6];
      4'd7:    aligned_s = cat_s[16:7];
      4'd8:    aligned_s = cat_s[17:8];
      4'd9:    aligned_s = cat_s[18:9];
      default: aligned_s = cat_s[9:0];
    endcase
  end

  tmds_symbol_decode u_decode (
    .sym     (aligned_s),
    .is_ctrl (is_ctrl_s),
    .ctrl    (dec_ctrl_s),
    .data    (dec_data_s)
  );

  // Lock status after this edge, so the symbol that completes the lock is output.
  always_comb begin
    lock_nxt_s = 1'b0;
    case (state_r)
      ST_CHECK: begin
        if (is_ctrl_s && (run_r == RUN_LAST)) begin
          lock_nxt_s = 1'b1;
        end else begin
          lock_nxt_s = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (!is_ctrl_s && (idle_r == IDLE_LAST)) begin
          lock_nxt_s = 1'b0;
        end else begin
          lock_nxt_s = 1'b1;
        end
      end
      default: lock_nxt_s = 1'b0;
    endcase
  end

  // Alignment FSM: slip while searching, qualify a run of tokens, watch for loss.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      state_r <= ST_SEARCH;
      wait_r  <= '0;
      run_r   <= '0;
      idle_r  <= '0;
      slip_r  <= 4'd0;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          if (is_ctrl_s) begin
            state_r <= ST_CHECK;
            run_r   <= CNT_ONE;
          end else if (wait_r == WAIT_LAST) begin
            slip_r <= next_offset(slip_r);
            wait_r <= '0;
          end else if (wait_r != CNT_SAT) begin
            wait_r <= wait_r + CNT_ONE;
          end else begin
            wait_r <= wait_r;
          end
        end
        ST_CHECK: begin
          if (!is_ctrl_s) begin
            state_r <= ST_SEARCH;
            run_r   <= '0;
            wait_r  <= '0;
          end else if (run_r == RUN_LAST) begin
            state_r <= ST_LOCKED;
            idle_r  <= '0;
          end else if (run_r != CNT_SAT) begin
            run_r <= run_r + CNT_ONE;
          end else begin
            run_r <= run_r;
          end
        end
        ST_LOCKED: begin
          if (is_ctrl_s) begin
            idle_r <= '0;
          end else if (idle_r == IDLE_LAST) begin
            state_r <= ST_SEARCH;
            wait_r  <= '0;
            run_r   <= '0;
          end else if (idle_r != CNT_SAT) begin
            idle_r <= idle_r + CNT_ONE;
          end else begin
            idle_r <= idle_r;
          end
        end
        default: begin
          state_r <= ST_SEARCH;
          wait_r  <= '0;
          run_r   <= '0;
          idle_r  <= '0;
        end
      endcase
    end
  end

  // Output stage: blank while unlocked, otherwise present data or control.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      locked_r <= 1'b0;
      de_r     <= 1'b0;
      data_r   <= 8'h00;
      ctrl_r   <= 2'b00;
    end else if (!lock_nxt_s) begin
      locked_r <= 1'b0;
      de_r     <= 1'b0;
      data_r   <= 8'h00;
      ctrl_r   <= 2'b00;
    end else if (is_ctrl_s) begin
      locked_r <= 1'b1;
      de_r     <= 1'b0;
      ctrl_r   <= dec_ctrl_s;
    end else begin
      locked_r <= 1'b1;
      de_r     <= 1'b1;
      data_r   <= dec_data_s;
    end
  end

  assign locked      = locked_r;
  assign slip_offset = slip_r;
  assign de          = de_r;
  assign data        = data_r;
  assign ctrl        = ctrl_r;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with short SLIP_WAIT/LOCK_COUNT/TIMEOUT.
module tb_tmds_decoder;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b0;
  logic [9:0] sym_in  = 10'h000;
  logic       locked;
  logic [3:0] slip_offset;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int skew  = 0;
  logic [9:0] prev_sym = 10'h354;

  tmds_decoder #(
    .SLIP_WAIT  (32),
    .LOCK_COUNT (8),
    .TIMEOUT    (64),
    .CNTW       (13)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .sym_in      (sym_in),
    .locked      (locked),
    .slip_offset (slip_offset),
    .de          (de),
    .data        (data),
    .ctrl        (ctrl)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one symbol on the wire, shifted by 'skew' bits into the word stream.
  task automatic tick_sym(input logic [9:0] s);
    logic [19:0] c;
    c        = {s, prev_sym} >> (10 - skew);
    sym_in   = c[9:0];
    prev_sym = s;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_reset();
    rst_pix = 1'b0;
    sym_in  = 10'h000;
    repeat (2) begin
      @(posedge clk_pix);
      #1;
    end
    rst_pix  = 1'b1;
    prev_sym = 10'h354;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 16'(locked), 16'h0);
    check({tag, "_slip"},   16'(slip_offset), 16'h0);
    check({tag, "_de"},     16'(de), 16'h0);
    check({tag, "_data"},   16'(data), 16'h0);
    check({tag, "_ctrl"},   16'(ctrl), 16'h0);
  endtask

  logic [9:0] t3_sym  [6];
  logic       t3_de   [6];
  logic [7:0] t3_data [6];
  logic [1:0] t3_ctrl [6];
  int         chg_tick [3];
  int         n_chg;
  int         lock_tick;
  logic [3:0] last_slip;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t3_sym[0] = 10'h100; t3_de[0] = 1'b1; t3_data[0] = 8'h00; t3_ctrl[0] = 2'b00;
    t3_sym[1] = 10'h1FF; t3_de[1] = 1'b1; t3_data[1] = 8'h01; t3_ctrl[1] = 2'b00;
    t3_sym[2] = 10'h0AB; t3_de[2] = 1'b0; t3_data[2] = 8'h01; t3_ctrl[2] = 2'b01;
    t3_sym[3] = 10'h0F0; t3_de[3] = 1'b1; t3_data[3] = 8'hEE; t3_ctrl[3] = 2'b01;
    t3_sym[4] = 10'h2AB; t3_de[4] = 1'b0; t3_data[4] = 8'hEE; t3_ctrl[4] = 2'b11;
    t3_sym[5] = 10'h154; t3_de[5] = 1'b0; t3_data[5] = 8'hEE; t3_ctrl[5] = 2'b10;

    // Test 1: aligned 0x354 stream locks after 8 tokens plus pipeline.
    do_reset();
    check_zero("rst");
    skew = 0;
    for (int t = 1; t <= 10; t++) begin
      tick_sym(10'h354);
      if (t == 9)  check("t1_not_yet", 16'(locked), 16'h0);
      if (t == 10) check("t1_locked", 16'(locked), 16'h1);
    end
    check("t1_slip", 16'(slip_offset), 16'h0);
    check("t1_ctrl", 16'(ctrl), 16'h0);
    check("t1_de",   16'(de), 16'h0);

    // Test 3: data/control decode while locked.
    for (int i = 0; i < 8; i++) begin
      tick_sym((i < 6) ? t3_sym[i] : 10'h354);
      if (i >= 2) begin
        check($sformatf("t3_de%0d", i - 2),   16'(de),   16'(t3_de[i-2]));
        check($sformatf("t3_data%0d", i - 2), 16'(data), 16'(t3_data[i-2]));
        check($sformatf("t3_ctrl%0d", i - 2), 16'(ctrl), 16'(t3_ctrl[i-2]));
        check($sformatf("t3_lock%0d", i - 2), 16'(locked), 16'h1);
      end
    end

    // Test 5: CHECK interrupted by a data symbol after 5 tokens.
    do_reset();
    skew = 0;
    for (int t = 1; t <= 16; t++) begin
      tick_sym((t == 6) ? 10'h100 : 10'h354);
      check($sformatf("t5_lock%0d", t), 16'(locked), (t >= 16) ? 16'h1 : 16'h0);
    end

    // Test 2: 3 bits of skew, slip steps every 32 cycles then locks at 3.
    do_reset();
    skew      = 3;
    n_chg     = 0;
    lock_tick = 0;
    last_slip = 4'd0;
    for (int i = 0; i < 3; i++) chg_tick[i] = -1;
    for (int t = 1; t <= 200 && locked !== 1'b1; t++) begin
      tick_sym(10'h354);
      if (slip_offset !== last_slip) begin
        if (n_chg < 3) chg_tick[n_chg] = t;
        n_chg++;
        last_slip = slip_offset;
      end
      lock_tick = t;
    end
    check("t2_nchg",  16'(n_chg), 16'd3);
    check("t2_chg1",  16'(chg_tick[0]), 16'd32);
    check("t2_chg2",  16'(chg_tick[1]), 16'd64);
    check("t2_chg3",  16'(chg_tick[2]), 16'd96);
    check("t2_lockt", 16'(lock_tick), 16'd104);
    check("t2_lock",  16'(locked), 16'h1);
    check("t2_slip",  16'(slip_offset), 16'd3);
    check("t2_ctrl",  16'(ctrl), 16'h0);

    // Test 4: 64 data symbols time out the lock; tokens relock at the same offset.
    for (int t = 1; t <= 66; t++) begin
      tick_sym(10'h1FF);
      if (t == 62) begin
        check("t4_lock62", 16'(locked), 16'h1);
        check("t4_de62",   16'(de), 16'h1);
        check("t4_data62", 16'(data), 16'h01);
      end
      if (t == 65) check("t4_lock65", 16'(locked), 16'h1);
    end
    check("t4_drop_lock", 16'(locked), 16'h0);
    check("t4_drop_de",   16'(de), 16'h0);
    check("t4_drop_data", 16'(data), 16'h0);
    check("t4_drop_ctrl", 16'(ctrl), 16'h0);
    check("t4_drop_slip", 16'(slip_offset), 16'd3);
    for (int t = 1; t <= 10; t++) begin
      tick_sym(10'h354);
      if (t == 9)  check("t4_relock_early", 16'(locked), 16'h0);
      if (t == 10) check("t4_relock", 16'(locked), 16'h1);
    end
    check("t4_relock_slip", 16'(slip_offset), 16'd3);

    // Test 6: one-cycle reset while locked at offset 3.
    rst_pix = 1'b0;
    tick_sym(10'h354);
    check_zero("t6");
    rst_pix = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      tick_sym(10'h354);
      if (t == 31) check("t6_slip31", 16'(slip_offset), 16'd0);
      if (t == 32) begin
        check("t6_slip32", 16'(slip_offset), 16'd1);
        check("t6_lock32", 16'(locked), 16'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
